// File: rtl/tartaruga_pkg.sv
// Shared types and defaults for the tartaruga core's memory-side blocks.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    // Longest run of LSU grants allowed while instruction fetch is waiting.
    localparam int unsigned DEFAULT_MAX_LS_BURST = 4;

    // Which requester owns the access currently sitting in the memory stage.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage : tartaruga_pkg

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory.
// LSU normally wins; a fetch that has been starved for MAX_LS_BURST LSU
// grants is let through. A grant in cycle N is captured into a one-deep
// stage and the memory access, response and any write happen in cycle N+1.
module mem_port_arbiter
    import tartaruga_pkg::*;
#(
    parameter int unsigned MAX_LS_BURST = DEFAULT_MAX_LS_BURST
) (
    input  logic   clk_i,
    input  logic   rstn_i,

    input  logic   if_req_i,
    input  bus32_t if_addr_i,
    output logic   if_gnt_o,
    output logic   if_rvalid_o,
    output bus32_t if_rdata_o,

    input  logic   ls_req_i,
    input  logic   ls_we_i,
    input  bus32_t ls_addr_i,
    input  bus32_t ls_wdata_i,
    output logic   ls_gnt_o,
    output logic   ls_rvalid_o,
    output bus32_t ls_rdata_o,

    output bus32_t mem_addr_o,
    output bus32_t mem_wdata_o,
    output logic   mem_we_o,
    input  bus32_t mem_rdata_i
);

    // A zero limit still needs a one-bit counter; it then simply never counts.
    localparam int unsigned    CNT_W       = (MAX_LS_BURST < 1) ? 1 : $clog2(MAX_LS_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_LS_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic             burst_full;
    logic             ls_win;
    logic             if_win;

    owner_e           own_q;
    bus32_t           addr_q;
    bus32_t           wdata_q;
    logic             we_q;
    logic             valid_q;

    // Same-cycle arbitration; grants are masked while reset is asserted.
    always_comb begin
        burst_full = (burst_cnt == BURST_LIMIT);
        ls_win     = ls_req_i && !(if_req_i && burst_full);
        if_win     = if_req_i && !ls_win;
        ls_gnt_o   = rstn_i && ls_win;
        if_gnt_o   = rstn_i && if_win;
    end

    // Count LSU grants that overtake a waiting fetch; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            burst_cnt <= '0;
        end else if (!if_req_i || if_gnt_o) begin
            burst_cnt <= '0;
        end else if (ls_gnt_o && !burst_full) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    // Capture the granted access; the address is kept when nothing is granted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            own_q   <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= ls_gnt_o || if_gnt_o;
            if (ls_gnt_o) begin
                own_q   <= OWN_LS;
                addr_q  <= ls_addr_i;
                wdata_q <= ls_wdata_i;
                we_q    <= ls_we_i;
            end else if (if_gnt_o) begin
                own_q   <= OWN_IF;
                addr_q  <= if_addr_i;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end
        end
    end

    // Drive the memory port and route the read data back to the stage owner.
    always_comb begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = valid_q && we_q;
        if_rvalid_o = valid_q && (own_q == OWN_IF);
        ls_rvalid_o = valid_q && (own_q == OWN_LS);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 64-word behavioural memory.
module tb_mem_port_arbiter;
    import tartaruga_pkg::*;

    localparam int unsigned MAXB = 4;

    logic   clk;
    logic   rstn;
    logic   if_req;
    bus32_t if_addr;
    logic   if_gnt, if_rvalid;
    bus32_t if_rdata;
    logic   ls_req, ls_we;
    bus32_t ls_addr, ls_wdata;
    logic   ls_gnt, ls_rvalid;
    bus32_t ls_rdata;
    bus32_t mem_addr, mem_wdata, mem_rdata;
    logic   mem_we;

    bus32_t mem     [0:63];
    bus32_t ref_mem [0:63];

    typedef struct {
        logic   valid;
        logic   is_ls;
        logic   we;
        bus32_t addr;
        bus32_t wdata;
        bus32_t data;
    } exp_t;

    exp_t   sb[$];
    int     vectors;
    int     miscompares;
    int     model_cnt;
    bus32_t last_addr;

    mem_port_arbiter #(.MAX_LS_BURST(MAXB)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .ls_req_i   (ls_req),
        .ls_we_i    (ls_we),
        .ls_addr_i  (ls_addr),
        .ls_wdata_i (ls_wdata),
        .ls_gnt_o   (ls_gnt),
        .ls_rvalid_o(ls_rvalid),
        .ls_rdata_o (ls_rdata),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    // Behavioural data memory: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input bus32_t obs, input bus32_t exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Compare the stage outputs against the oldest scoreboard entry.
    task automatic checkResponse();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checkOutput("if_rvalid", {31'd0, if_rvalid}, {31'd0, e.valid && !e.is_ls});
        checkOutput("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, e.valid && e.is_ls});
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e.valid && e.we});
        if (e.valid) begin
            checkOutput("mem_addr", mem_addr, e.addr);
            if (!e.is_ls) checkOutput("if_rdata", if_rdata, e.data);
            if (e.is_ls && !e.we) checkOutput("ls_rdata", ls_rdata, e.data);
            if (e.is_ls && e.we) begin
                checkOutput("mem_wdata", mem_wdata, e.wdata);
                ref_mem[e.addr[7:2]] = e.wdata;
            end
            last_addr = e.addr;
        end else begin
            checkOutput("mem_addr_hold", mem_addr, last_addr);
        end
    endtask

    // One cycle: check last cycle's response, drive new requests, check grants.
    task automatic applyStimulus(input logic ifr, input bus32_t ifa, input logic lsr,
                                 input logic lsw, input bus32_t lsa, input bus32_t lsd);
        logic exp_ls, exp_if;
        exp_t e;
        @(negedge clk);
        checkResponse();
        if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_we = lsw; ls_addr = lsa; ls_wdata = lsd;
        #1;
        exp_ls = lsr && !(ifr && (model_cnt == MAXB));
        exp_if = ifr && !exp_ls;
        checkOutput("if_gnt", {31'd0, if_gnt}, {31'd0, exp_if});
        checkOutput("ls_gnt", {31'd0, ls_gnt}, {31'd0, exp_ls});
        if (if_gnt && ls_gnt) checkOutput("one_grant", 32'd2, 32'd1);
        e.valid = exp_ls || exp_if;
        e.is_ls = exp_ls;
        e.we    = exp_ls && lsw;
        e.addr  = exp_ls ? lsa : ifa;
        e.wdata = lsd;
        e.data  = ref_mem[e.addr[7:2]];
        sb.push_back(e);
        if (!ifr || exp_if) model_cnt = 0;
        else if (exp_ls && model_cnt < MAXB) model_cnt++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, {30'd0, if_gnt, ls_gnt}, 32'd0);
        checkOutput({tag, "_rvalid"}, {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 32'd0);
        checkOutput({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; model_cnt = 0; last_addr = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

        // Reset with both requests high: everything including grants must be 0.
        rstn = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h1;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        rstn = 1'b1;

        // Fetch-only read of word 4.
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // LSU write then read of the same word.
        applyStimulus(0, 0, 1, 1, 32'h20, 32'h12345678);
        applyStimulus(0, 0, 1, 0, 32'h20, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Contention: LS,LS,LS,LS,IF repeating.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'h10, 1, 0, 32'h40 + 32'(i * 4), 0);
            checkOutput("pattern", {31'd0, ls_gnt}, {31'd0, (i % 5) != 4});
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Eight back-to-back LSU reads.
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 32'h80 + 32'(i * 4), 0);

        // Fetch stalled behind LSU then dropped: no fetch response.
        applyStimulus(1, 32'h14, 1, 0, 32'h24, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Fetch with stale write strobe on the idle LSU port.
        applyStimulus(1, 32'h10, 0, 1, 32'h10, 32'hBAD0BAD0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fetch_no_write", mem[4], 32'hDEADBEEF);

        // Reset while a granted LSU write is in the memory stage.
        applyStimulus(0, 0, 1, 1, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        rstn = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        #1;
        checkAllZero("midrst");
        sb.delete();
        model_cnt = 0; last_addr = '0;
        repeat (2) @(posedge clk);
        checkOutput("midrst_mem", mem[12], ref_mem[12]);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        rstn = 1'b1;
        begin
            exp_t idle;
            idle.valid = 1'b0; idle.is_ls = 1'b0; idle.we = 1'b0;
            idle.addr = '0; idle.wdata = '0; idle.data = '0;
            sb.push_back(idle);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h30, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkResponse();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_LS_BURST, default 4: the maximum number of consecutive LSU grants while a fetch request waits.
REQ-002 The block SHALL have port clk_i, input, 1: clock, all state updated on its rising edge.
REQ-003 The block SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port if_req_i, input, 1: fetch read request, held until granted.
REQ-005 The block SHALL have port if_addr_i, input, 32 (bus32_t): fetch byte address.
REQ-006 The block SHALL have port if_gnt_o, output, 1: fetch request accepted this cycle.
REQ-007 The block SHALL have ports if_rvalid_o (output, 1) and if_rdata_o (output, 32): fetch response.
REQ-008 The block SHALL have ports ls_req_i, ls_we_i (input, 1 each) and ls_addr_i, ls_wdata_i (input, 32 each): LSU request.
REQ-009 The block SHALL have ports ls_gnt_o, ls_rvalid_o (output, 1 each) and ls_rdata_o (output, 32): LSU grant and response; a write response is an ack.
REQ-010 The block SHALL have ports mem_addr_o, mem_wdata_o (output, 32 each) and mem_we_o (output, 1): single memory port, combinational read, write on clock edge.
REQ-011 The block SHALL have port mem_rdata_i, input, 32: memory read data for mem_addr_o in the same cycle.

Function
REQ-012 At most one of if_gnt_o and ls_gnt_o SHALL be high in any cycle; a grant is combinational on the same-cycle request.
REQ-013 Priority SHALL be LSU over fetch, except that fetch wins when burst_cnt == MAX_LS_BURST and if_req_i is high.
REQ-014 burst_cnt SHALL increment on each LSU grant while if_req_i is high, saturate at MAX_LS_BURST, and clear on any fetch grant or any cycle with if_req_i low.
REQ-015 A grant in cycle N SHALL register owner, address, write data and write enable; the memory access is performed in cycle N+1 from these registers.
REQ-016 In cycle N+1 mem_we_o SHALL equal the registered write enable ANDed with the registered valid; mem_addr_o and mem_wdata_o SHALL come from the registers.
REQ-017 The granted port's rvalid SHALL be high exactly in cycle N+1, with rdata = mem_rdata_i; for writes ls_rdata_o is don't-care.
REQ-018 Fetch requests SHALL never write memory; ls_we_i is ignored on a fetch grant.
REQ-019 Grants SHALL be issued back-to-back: the stage holds one access, refilled every cycle, for a throughput of 1 access per cycle.
REQ-020 With no grant in cycle N, the stage SHALL be invalid in N+1: mem_we_o = 0, both rvalid = 0, and mem_addr_o holds its last value.
REQ-021 When both requests are high with burst_cnt < MAX_LS_BURST, LSU SHALL be granted and fetch stalls without a grant.
REQ-022 A requester dropping req before grant SHALL cancel the request with no side effect.

Reset
REQ-023 On rstn_i low, immediately: stage valid = 0, burst_cnt = 0, owner = fetch, registered address, data and write enable = 0.
REQ-024 During reset all outputs SHALL be 0, including grants; the grant is forced low while rstn_i is low.
REQ-025 Reset during a pending access SHALL drop it: no rvalid and no memory write after deassertion.

Structure
REQ-026 bus32_t and the default of MAX_LS_BURST SHALL live in tartaruga_pkg; the owner encoding (OWN_IF, OWN_LS) SHALL be a package enum.
REQ-027 The block SHALL be a single module without sub-modules, instantiated in front of the data memory.

Verification
REQ-028 Fetch-only: if_req = 1, addr 0x10, memory word 4 = 0xDEADBEEF -> if_gnt in cycle 0, if_rvalid in cycle 1 with if_rdata = 0xDEADBEEF.
REQ-029 LSU write then read: write 0x20 <= 0x12345678, then read 0x20 -> mem_we high for one cycle, ls_rvalid each cycle, read data = 0x12345678.
REQ-030 Contention: both requests held for 10 cycles, MAX_LS_BURST = 4 -> grant pattern LS,LS,LS,LS,IF repeated; never two grants in one cycle.
REQ-031 Back-to-back: 8 consecutive LSU reads -> 8 consecutive rvalid cycles, each with the correct word, no bubbles.
REQ-032 Reset mid-access: grant an LSU write, assert rstn_i low in cycle N+1 before the edge -> memory word unchanged, no rvalid, all outputs 0.
REQ-033 Fetch with ls_we-style stimulus: if_req plus stale ls_we_i = 1 with ls_req = 0 -> mem_we_o stays 0 and fetch data is returned.
